// File: rtl/hkspi_stream_master_if.sv
// Command/data stream bundle between a host and the housekeeping SPI stream master.
interface hkspi_stream_master_if #(
  parameter int LEN_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [7:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/hkspi_stream_master.sv
// Housekeeping SPI stream master: opcode + address + N data bytes, SPI mode 0, MSB first.
module hkspi_stream_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  hkspi_stream_master_if.slave  bus,
  output logic                  spi_csb,
  output logic                  spi_sck,
  output logic                  spi_sdi,
  input  logic                  spi_sdo
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  localparam logic [1:0] ST_OPC  = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       stage;
  logic [LEN_W-1:0] remaining;
  logic             wr_mode;
  logic [7:0]       addr;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [7:0]       load_byte;
  logic             load_go;
  logic             div_end;

  always_comb begin
    div_end   = (cnt == DIV_LAST);
    load_byte = '0;
    case (stage)
      ST_OPC:  load_byte = wr_mode ? 8'h80 : 8'h40;
      ST_ADDR: load_byte = addr;
      default: load_byte = wr_mode ? bus.wr_data : 8'h00;
    endcase
    load_go = !(stage == ST_DATA && wr_mode && !bus.wr_valid);
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.wr_ready  = (state == LOAD) && (stage == ST_DATA) && wr_mode;
  assign bus.done      = (state == GAP) && div_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      stage       <= ST_OPC;
      remaining   <= '0;
      wr_mode     <= 1'b0;
      addr        <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
      spi_csb     <= 1'b1;
      spi_sck     <= 1'b0;
      spi_sdi     <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            wr_mode   <= bus.cmd_write;
            addr      <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            stage     <= ST_OPC;
            cnt       <= '0;
            spi_csb   <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          if (load_go) begin
            tx_sr   <= load_byte;
            spi_sdi <= load_byte[7];
            bit_cnt <= 3'd7;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            // sdo is captured on the same edge that raises sck, before the slave can change it
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[6:0], spi_sdo};
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt != 3'd0) begin
                bit_cnt <= bit_cnt - 1'b1;
                tx_sr   <= {tx_sr[6:0], 1'b0};
                spi_sdi <= tx_sr[6];
              end else begin
                spi_sdi <= 1'b0;
                case (stage)
                  ST_OPC: begin
                    stage <= ST_ADDR;
                    state <= LOAD;
                  end
                  ST_ADDR: begin
                    stage <= ST_DATA;
                    state <= (remaining == LEN_W'(0)) ? HOLD : LOAD;
                  end
                  default: begin
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == LEN_W'(1)) ? HOLD : LOAD;
                    if (!wr_mode) begin
                      bus.rd_valid <= 1'b1;
                      bus.rd_data  <= rx_sr;
                    end
                  end
                endcase
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            cnt     <= '0;
            spi_csb <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hkspi_stream_master.sv
// Scoreboard bench for hkspi_stream_master against a housekeeping SPI slave register model.
module tb_hkspi_stream_master;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hkspi_stream_master_if #(.LEN_W(6)) bus ();
  hkspi_stream_master_if #(.LEN_W(6)) bus2 ();

  logic csb, sck, sdi, sdo;
  logic csb2, sck2, sdi2;

  hkspi_stream_master #(.CLK_DIV(2), .LEN_W(6)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .spi_csb(csb), .spi_sck(sck), .spi_sdi(sdi), .spi_sdo(sdo)
  );

  hkspi_stream_master #(.CLK_DIV(1), .LEN_W(6)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .spi_csb(csb2), .spi_sck(sck2), .spi_sdi(sdi2), .spi_sdo(1'b0)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  int exp_wire[$];
  int exp_rd[$];
  int wq[$];

  logic [7:0] regs [0:255];
  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[0]  = 8'h00; regs[1]  = 8'h04; regs[2]  = 8'h56; regs[3]  = 8'h11;
    regs[4]  = 8'h00; regs[5]  = 8'h00; regs[6]  = 8'h00; regs[7]  = 8'h00;
    regs[8]  = 8'h02; regs[9]  = 8'h01; regs[10] = 8'h00; regs[11] = 8'h00;
    regs[12] = 8'h00; regs[13] = 8'hff; regs[14] = 8'hef; regs[15] = 8'hff;
    regs[16] = 8'h03; regs[17] = 8'h12; regs[18] = 8'h04;
  end

  // slave model: shifts sdi in on sck rise, presents the next read bit right after
  int         sl_bit = 0;
  int         sl_idx = 0;
  logic [7:0] sl_in = '0, sl_out = '0, sl_op = '0, sl_addr = '0;
  assign sdo = sl_out[7];

  always @(posedge sck or posedge csb) begin
    if (csb) begin
      sl_bit = 0;
      sl_idx = 0;
      sl_out = '0;
    end else begin
      sl_in  = {sl_in[6:0], sdi};
      sl_out = {sl_out[6:0], 1'b0};
      sl_bit++;
      if (sl_bit == 8) begin
        sl_bit = 0;
        check("wire_byte", int'(sl_in), exp_wire.size() > 0 ? exp_wire.pop_front() : 256);
        if (sl_idx == 0) sl_op = sl_in;
        else if (sl_idx == 1) sl_addr = sl_in;
        sl_idx++;
        if (sl_idx >= 2 && sl_op == 8'h40) sl_out = regs[8'(int'(sl_addr) + sl_idx - 2)];
      end
    end
  end

  int csb_low = 0, done_cnt = 0, rd_cnt = 0, wr_taken = 0, stall_seen = 0;
  int sck_viol = 0, busy_viol = 0, stall_viol = 0;
  int stall_idx = -1, stall_left = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (!csb) csb_low++;
      if (bus.done) done_cnt++;
      if (bus.rd_valid) begin
        rd_cnt++;
        check("rd_data", int'(bus.rd_data), exp_rd.size() > 0 ? exp_rd.pop_front() : 256);
      end
      if (csb && sck) sck_viol++;
      if (bus.busy == bus.cmd_ready) busy_viol++;
      if (bus.wr_ready && !bus.wr_valid) begin
        stall_seen++;
        if (csb || sck) stall_viol++;
      end
    end
  end

  initial begin : wr_driver
    bit hs;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    forever begin
      @(negedge clock);
      hs = bus.wr_ready && bus.wr_valid;
      @(posedge clock);
      #1;
      if (hs && wq.size() > 0) begin
        void'(wq.pop_front());
        wr_taken++;
      end
      if (bus.wr_ready && wr_taken == stall_idx && stall_left > 0) begin
        bus.wr_valid = 1'b0;
        stall_left--;
      end else begin
        bus.wr_valid = (wq.size() > 0);
        bus.wr_data  = (wq.size() > 0) ? 8'(wq[0]) : 8'h00;
      end
    end
  end

  int csb2_low = 0, done2 = 0, rd2 = 0, wrr2 = 0, nbits2 = 0;
  logic [15:0] bits2 = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (!csb2) csb2_low++;
      if (bus2.done) done2++;
      if (bus2.rd_valid) rd2++;
      if (bus2.wr_ready) wrr2++;
    end
  end
  always @(posedge sck2) begin
    bits2 = {bits2[14:0], sdi2};
    nbits2++;
  end

  task automatic run_txn(input string tag, input bit wr, input logic [7:0] addr, input int len,
                         input int st_idx, input int st_n, input int exp_csb);
    csb_low = 0; done_cnt = 0; rd_cnt = 0; wr_taken = 0; stall_seen = 0;
    stall_idx = st_idx; stall_left = st_n;
    exp_wire.push_back(wr ? 8'h80 : 8'h40);
    exp_wire.push_back(int'(addr));
    for (int i = 0; i < len; i++) exp_wire.push_back(wr ? wq[i] : 0);
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = 6'(len);
    @(negedge clock);
    bus.cmd_write = ~wr; bus.cmd_addr = ~addr; bus.cmd_len = 6'(len + 5);
    repeat (2) @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clock);
    repeat (6) @(negedge clock);
    check({tag, "_csb_low"}, csb_low, exp_csb);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_rd_cnt"}, rd_cnt, wr ? 0 : len);
    check({tag, "_wr_taken"}, wr_taken, wr ? len : 0);
    check({tag, "_wire_left"}, exp_wire.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    exp_wire.delete();
    exp_rd.delete();
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int reached;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_addr = '0; bus2.cmd_len = '0;
    bus2.wr_valid = 1'b0; bus2.wr_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_csb", csb, 1);
    check("rst_sck", sck, 0);
    check("rst_sdi", sdi, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // read 0x03 len 1: 2*2 + 3*33 = 103
    exp_rd.push_back(8'h11);
    run_txn("rd1", 1'b0, 8'h03, 1, -1, 0, 103);

    wq.push_back(8'h01);
    run_txn("wr1", 1'b1, 8'h0b, 1, -1, 0, 103);

    // read 19 bytes from 0x00: 4 + 21*33 = 697
    begin
      int vals[19] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                       8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
      foreach (vals[i]) exp_rd.push_back(vals[i]);
    end
    run_txn("rd19", 1'b0, 8'h00, 19, -1, 0, 697);

    // write len 2 with 20-cycle stall before byte 2: 4 + 4*33 + 20 = 156
    wq.push_back(8'ha5);
    wq.push_back(8'h3c);
    run_txn("wr_stall", 1'b1, 8'h20, 2, 1, 20, 156);
    check("stall_cycles", stall_seen, 20);

    // max length write: 4 + 65*33 = 2149
    for (int i = 0; i < 63; i++) wq.push_back((i * 7 + 1) & 255);
    run_txn("wr_max", 1'b1, 8'h40, 63, -1, 0, 2149);

    // abort during bit 4 of the address byte
    done_cnt = 0; rd_cnt = 0;
    exp_wire.push_back(8'h40);
    exp_wire.push_back(8'h03);
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h03; bus.cmd_len = 6'd1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    reached = 0;
    for (int c = 0; c < 2000 && reached == 0; c++) begin
      @(negedge clock);
      if (sl_idx == 1 && sl_bit == 3 && !sck && !csb) reached = 1;
    end
    check("abort_reached", reached, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_csb", csb, 1);
    check("abort_sck", sck, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_rd_valid", bus.rd_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_rd_cnt", rd_cnt, 0);
    exp_wire.delete();
    exp_rd.delete();
    exp_rd.push_back(8'h11);
    run_txn("rd_after_abort", 1'b0, 8'h03, 1, -1, 0, 103);

    // CLK_DIV=1, len 0: 2 + 2*17 = 36
    csb2_low = 0; done2 = 0; rd2 = 0; wrr2 = 0; nbits2 = 0;
    @(negedge clock);
    bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b0; bus2.cmd_addr = 8'h05; bus2.cmd_len = 6'd0;
    @(negedge clock);
    bus2.cmd_valid = 1'b0;
    for (int c = 0; c < 2000 && done2 == 0; c++) @(negedge clock);
    repeat (4) @(negedge clock);
    check("div1_bits", nbits2, 16);
    check("div1_wire", int'(bits2), 16'h4005);
    check("div1_csb_low", csb2_low, 36);
    check("div1_done", done2, 1);
    check("div1_rd_valid", rd2, 0);
    check("div1_wr_ready", wrr2, 0);

    check("sck_high_while_csb_high", sck_viol, 0);
    check("busy_vs_cmd_ready", busy_viol, 0);
    check("stall_pins", stall_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hkspi_stream_master.md
HKSPI_STREAM_MASTER -- requirements
Module: hkspi_stream_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clock cycles; legal values are 1 or greater.
REQ-002 Parameter LEN_W, default 6: width of the data-byte count field.
REQ-003 clock  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  synchronous reset, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block is idle and accepts a command.
REQ-007 cmd_write  in  1  1 selects a write stream (opcode 0x80); 0 selects a read stream (opcode 0x40).
REQ-008 cmd_addr  in  8  start register address.
REQ-009 cmd_len  in  LEN_W  number of data bytes following the address byte; 0 is legal.
REQ-010 wr_data  in  8  next write byte.
REQ-011 wr_valid  in  1  wr_data is valid.
REQ-012 wr_ready  out  1  block is consuming a write byte this cycle.
REQ-013 rd_data  out  8  received byte.
REQ-014 rd_valid  out  1  one-cycle strobe for rd_data; there is no backpressure.
REQ-015 busy  out  1  a transaction is in progress.
REQ-016 done  out  1  one-cycle strobe at transaction end.
REQ-017 spi_csb, spi_sck, spi_sdi  out  1 each  housekeeping SPI pins.
REQ-018 spi_sdo  in  1  housekeeping SPI data from the slave.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, LOAD, SHIFT, HOLD and GAP.
REQ-020 IDLE: cmd_ready=1. On cmd_valid, the block SHALL latch write/addr/len, drive csb=0 on the next cycle and enter SETUP.
REQ-021 SETUP: the block SHALL stay CLK_DIV cycles with sck=0, then enter LOAD.
REQ-022 LOAD: the block SHALL take 1 cycle to load the shift register with, in order, the opcode, then cmd_addr, then the data bytes, and then enter SHIFT.
REQ-023 Write data byte in LOAD: wr_ready=1, and the byte is taken when wr_valid=1. If wr_valid=0, the block SHALL stall in LOAD indefinitely with csb=0 and sck=0.
REQ-024 Read data byte in LOAD: the shift register SHALL be loaded with 0x00, so sdi=0 throughout the byte.
REQ-025 SHIFT sends 8 bits, MSB first, in SPI mode 0. Per bit:
- sdi is updated at the start of the sck-low phase.
- sck is low for CLK_DIV cycles, then high for CLK_DIV cycles.
- spi_sdo is sampled on the cycle sck goes from 0 to 1.
REQ-026 After bit 0 of a read data byte, the block SHALL assert rd_valid for 1 cycle with rd_data equal to the 8 sampled bits (first sample = bit 7). Opcode and address bytes SHALL NOT produce rd_valid.
REQ-027 After each byte, the block SHALL go to LOAD if bytes remain, otherwise to HOLD.
REQ-028 HOLD: the block SHALL stay CLK_DIV cycles with sck=0, then raise csb to 1 and enter GAP.
REQ-029 GAP: the block SHALL stay CLK_DIV cycles with csb=1, then return to IDLE. done=1 SHALL be asserted in the final GAP cycle.
REQ-030 Total bytes per transaction SHALL be 2+cmd_len.
REQ-031 With no stalls, csb SHALL be low for exactly 2*CLK_DIV + (2+L)*(16*CLK_DIV+1) cycles, where L = cmd_len.
REQ-032 busy SHALL equal !cmd_ready.
REQ-033 cmd_valid SHALL be ignored while busy=1.
REQ-034 sck SHALL be 0 whenever csb=1.
REQ-035 cmd_len at its maximum value (2^LEN_W - 1) SHALL work with no count wrap.
REQ-036 All pin outputs SHALL be registered, with no glitches.

Reset
REQ-037 While reset=1, the block SHALL be in IDLE with:
- csb=1, sck=0, sdi=0;
- cmd_ready=1, busy=0;
- wr_ready=0, rd_valid=0, done=0;
- rd_data=0x00.
REQ-038 Reset asserted mid-transaction SHALL abort it; the REQ-037 values SHALL appear on the cycle after reset is sampled, with no done and no rd_valid.
REQ-039 reset SHALL take priority over cmd_valid in the same cycle.

Verification
REQ-040 With CLK_DIV=2, read with addr 0x03, len 1, and the slave model returning 0x11 -> SDI carries 0x40, 0x03, 0x00; one rd_valid with rd_data=0x11; csb low for 103 cycles; done once.
REQ-041 Write with addr 0x0b, len 1, wr_data 0x01 -> SDI carries 0x80, 0x0b, 0x01; wr_ready pulses once; no rd_valid; done once.
REQ-042 Read with addr 0x00, len 19, against the slave register model -> 19 rd_valid strobes in the order 0x00, 0x04, 0x56, 0x11, 0x00, 0x00, 0x00, 0x00, 0x02, 0x01, 0x00, 0x00, 0x00, 0xff, 0xef, 0xff, 0x03, 0x12, 0x04.
REQ-043 Write with len 2 and wr_valid withheld for 20 cycles before byte 2 -> csb=0 and sck=0 throughout the stall; the csb-low time grows by exactly 20 cycles; bytes on the wire are correct.
REQ-044 Reset asserted during bit 4 of the address byte -> next cycle csb=1, sck=0, cmd_ready=1, no done; the following read of addr 0x03 returns 0x11.
REQ-045 With len 0 and CLK_DIV=1 -> exactly 2 bytes on the wire, csb low for 36 cycles, done once, no rd_valid and no wr_ready.
